image_ram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port picture RAM, which two requesters share. The first is the pipeline memory stage: picture-write ops, pixel and kernel loads, and LDR/STR that decode into the image region. The second is the display scan-out reader. The block accepts one transaction at a time, grants round-robin on contention and drives the RAM port from registers. It returns read data with a completion pulse and produces the memory-stage stall for the hazard unit.

---
 rtl/image_ram_arbiter.sv | 109 ++++++++++
 tb/tb_image_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_ram_arbiter.sv
// Arbiter/sequencer for the single-port picture RAM shared by the memory stage
// and the display scan-out reader; one transaction outstanding, round-robin on ties.
module image_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              stall,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_WR  = 2'd1,
    CPU_RD  = 2'd2,
    DISP_RD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              last_disp;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] disp_q;
  logic              grant_cpu, grant_disp;
  logic              cpu_rd_done;

  always_comb begin
    state_nxt  = state;
    grant_cpu  = 1'b0;
    grant_disp = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        if (cpu_req && disp_req) begin
          grant_cpu  = last_disp;
          grant_disp = ~last_disp;
        end else begin
          grant_cpu  = cpu_req;
          grant_disp = disp_req;
        end
        if (grant_cpu)       state_nxt = cpu_we ? CPU_WR : CPU_RD;
        else if (grant_disp) state_nxt = DISP_RD;
      end
      CPU_WR:          state_nxt = IDLE;
      CPU_RD, DISP_RD: if (cnt == '0) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_rd_done = (state == CPU_RD) && (cnt == '0);
    cpu_done    = (state == CPU_WR) || cpu_rd_done;
    disp_valid  = (state == DISP_RD) && (cnt == '0);
    cpu_rdata   = cpu_rd_done ? ram_rdata : '0;
    disp_rdata  = disp_valid ? ram_rdata : disp_q;
    stall       = cpu_req & ~cpu_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_disp    <= 1'b0;
      cnt          <= '0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      disp_q       <= '0;
      conflict_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ram_en <= grant_cpu | grant_disp;
      ram_we <= grant_cpu & cpu_we;
      if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        last_disp <= 1'b0;
      end else if (grant_disp) begin
        ram_addr  <= disp_addr;
        last_disp <= 1'b1;
      end
      if (grant_cpu || grant_disp)
        cnt <= 3'(RD_LAT - 1);
      else if ((state == CPU_RD || state == DISP_RD) && cnt != '0)
        cnt <= cnt - 3'd1;
      if (disp_valid)
        disp_q <= ram_rdata;
      if (state == IDLE && cpu_req && disp_req && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Directed bench for image_ram_arbiter: RD_LAT=2 main instance plus RD_LAT=1 and
// RD_LAT=4 instances, each with its own fixed-latency RAM model.
module tb_image_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [15:0] cpu_addr, disp_addr;
  logic [31:0] cpu_wdata;

  logic        cpu_req_v  [3];
  logic        disp_req_v [3];
  logic [31:0] cpu_rdata_v[3];
  logic        cpu_done_v [3];
  logic        stall_v    [3];
  logic [31:0] disp_rdata_v[3];
  logic        disp_valid_v[3];
  logic        ram_en_v   [3];
  logic        ram_we_v   [3];
  logic [15:0] ram_addr_v [3];
  logic [31:0] ram_wdata_v[3];
  logic [31:0] ram_rdata_v[3];
  logic [15:0] conflict_v [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 4 : 2;
  endfunction

  function automatic logic [31:0] rd_model(input logic [15:0] a);
    return (a == 16'h0100) ? 32'h00AB_CDEF : {16'hA5A5, a};
  endfunction

  image_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_v[0]), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_v[0]),
    .cpu_done(cpu_done_v[0]), .stall(stall_v[0]), .disp_req(disp_req_v[0]),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata_v[0]), .disp_valid(disp_valid_v[0]),
    .ram_en(ram_en_v[0]), .ram_we(ram_we_v[0]), .ram_addr(ram_addr_v[0]),
    .ram_wdata(ram_wdata_v[0]), .ram_rdata(ram_rdata_v[0]), .conflict_cnt(conflict_v[0]));

  image_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_v[1]), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_v[1]),
    .cpu_done(cpu_done_v[1]), .stall(stall_v[1]), .disp_req(disp_req_v[1]),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata_v[1]), .disp_valid(disp_valid_v[1]),
    .ram_en(ram_en_v[1]), .ram_we(ram_we_v[1]), .ram_addr(ram_addr_v[1]),
    .ram_wdata(ram_wdata_v[1]), .ram_rdata(ram_rdata_v[1]), .conflict_cnt(conflict_v[1]));

  image_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_v[2]), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_v[2]),
    .cpu_done(cpu_done_v[2]), .stall(stall_v[2]), .disp_req(disp_req_v[2]),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata_v[2]), .disp_valid(disp_valid_v[2]),
    .ram_en(ram_en_v[2]), .ram_we(ram_we_v[2]), .ram_addr(ram_addr_v[2]),
    .ram_wdata(ram_wdata_v[2]), .ram_rdata(ram_rdata_v[2]), .conflict_cnt(conflict_v[2]));

  // RAM model: data is valid only in cycle (ram_en cycle + RD_LAT - 1), garbage otherwise.
  logic [2:0]  ep[3];
  logic [15:0] ap[3][3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ep[k]    <= {ep[k][1:0], ram_en_v[k]};
      ap[k][0] <= ram_addr_v[k];
      ap[k][1] <= ap[k][0];
      ap[k][2] <= ap[k][1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      int          l;
      logic        v;
      logic [15:0] a;
      l = lat_of(k);
      v = 1'b0;
      a = '0;
      if (l == 1) begin
        v = ram_en_v[k];
        a = ram_addr_v[k];
      end else begin
        v = ep[k][l-2];
        a = ap[k][l-2];
      end
      ram_rdata_v[k] = v ? rd_model(a) : 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Returns the number of negedges until ram_en of the main instance is seen.
  task automatic wait_en(input int limit, output int n);
    n = limit + 1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (ram_en_v[0]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_lat(input int k);
    int n;
    n = 99;
    cyc();
    cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 32'h1234_5678;
    cpu_req_v[k] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("lat_en_c1", ram_en_v[k], 1);
        check("lat_we_c1", ram_we_v[k], 0);
        check("lat_wdata_c1", ram_wdata_v[k], 32'h1234_5678);
      end
      if (cpu_done_v[k]) begin
        n = c;
        check("lat_rdata", cpu_rdata_v[k], 32'hA5A5_0020);
        check("lat_stall_done", stall_v[k], 0);
        break;
      end
      cyc();
    end
    check("lat_done_cycle", n, lat_of(k));
    check("lat_disp_idle", {disp_valid_v[k], disp_rdata_v[k]}, 33'h0);
    check("lat_conflict", conflict_v[k], 0);
    cyc();
    cpu_req_v[k] = 1'b0;
  endtask

  initial begin
    int gap;
    rst_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; disp_addr = '0; cpu_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      cpu_req_v[k] = 1'b0;
      disp_req_v[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    smp();
    check("rst_ram_en", ram_en_v[0], 0);
    check("rst_conflict", conflict_v[0], 0);
    check("rst_disp_rdata", disp_rdata_v[0], 0);
    check("rst_done", {cpu_done_v[0], disp_valid_v[0], stall_v[0]}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted in the middle of a CPU read
    cyc(); cpu_req_v[0] = 1'b1; cpu_addr = 16'h0005;
    smp(); check("a_stall_c0", stall_v[0], 1);
    cyc(); smp();
    check("a_en_c1", ram_en_v[0], 1);
    check("a_addr_c1", ram_addr_v[0], 16'h0005);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_en", ram_en_v[0], 0);
    check("rst_mid_addr", ram_addr_v[0], 0);
    check("rst_mid_done", cpu_done_v[0], 0);
    check("rst_mid_stall", stall_v[0], 1);
    cpu_req_v[0] = 1'b0;
    #1 check("rst_stall_drop", stall_v[0], 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Uncontended CPU read after reset
    cyc(); cpu_req_v[0] = 1'b1; cpu_addr = 16'h0007;
    smp(); check("r_stall_c0", stall_v[0], 1); check("r_en_c0", ram_en_v[0], 0);
    cyc(); smp(); check("r_en_c1", ram_en_v[0], 1); check("r_done_c1", cpu_done_v[0], 0);
    check("r_stall_c1", stall_v[0], 1);
    cyc(); smp(); check("r_done_c2", cpu_done_v[0], 1);
    check("r_rdata_c2", cpu_rdata_v[0], 32'hA5A5_0007);
    check("r_stall_c2", stall_v[0], 0); check("r_en_c2", ram_en_v[0], 0);
    cyc(); cpu_req_v[0] = 1'b0;
    smp(); check("r_done_c3", cpu_done_v[0], 0); check("r_en_c3", ram_en_v[0], 0);

    // CPU write
    cyc(); cpu_req_v[0] = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEAD_BEEF;
    smp(); check("w_stall_c0", stall_v[0], 1); check("w_done_c0", cpu_done_v[0], 0);
    cyc(); smp();
    check("w_en_we_c1", {ram_en_v[0], ram_we_v[0]}, 2'b11);
    check("w_addr_c1", ram_addr_v[0], 16'h0010);
    check("w_wdata_c1", ram_wdata_v[0], 32'hDEAD_BEEF);
    check("w_done_c1", cpu_done_v[0], 1); check("w_stall_c1", stall_v[0], 0);
    cyc(); cpu_req_v[0] = 1'b0; cpu_we = 1'b0;
    smp(); check("w_en_c2", ram_en_v[0], 0); check("w_done_c2", cpu_done_v[0], 0);

    // Display read
    cyc(); disp_req_v[0] = 1'b1; disp_addr = 16'h0100;
    smp(); check("d_valid_c0", disp_valid_v[0], 0);
    cyc(); smp(); check("d_en_c1", ram_en_v[0], 1); check("d_we_c1", ram_we_v[0], 0);
    check("d_addr_c1", ram_addr_v[0], 16'h0100); check("d_valid_c1", disp_valid_v[0], 0);
    cyc(); smp(); check("d_valid_c2", disp_valid_v[0], 1);
    check("d_rdata_c2", disp_rdata_v[0], 32'h00AB_CDEF); check("d_we_c2", ram_we_v[0], 0);
    cyc(); disp_req_v[0] = 1'b0;
    smp(); check("d_valid_c3", disp_valid_v[0], 0);
    check("d_rdata_hold", disp_rdata_v[0], 32'h00AB_CDEF);

    // Simultaneous requests out of reset: display wins the first tie
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    cyc(); cpu_req_v[0] = 1'b1; cpu_addr = 16'h0001; disp_req_v[0] = 1'b1; disp_addr = 16'h0002;
    smp(); check("t_conf_c0", conflict_v[0], 0); check("t_en_c0", ram_en_v[0], 0);
    cyc(); smp(); check("t_en_c1", ram_en_v[0], 1); check("t_addr_c1", ram_addr_v[0], 16'h0002);
    check("t_conf_c1", conflict_v[0], 1);
    cyc(); smp(); check("t_valid_c2", disp_valid_v[0], 1);
    check("t_drdata_c2", disp_rdata_v[0], 32'hA5A5_0002);
    cyc(); disp_req_v[0] = 1'b0;
    smp(); check("t_en_c3", ram_en_v[0], 0); check("t_stall_c3", stall_v[0], 1);
    cyc(); smp(); check("t_en_c4", ram_en_v[0], 1); check("t_addr_c4", ram_addr_v[0], 16'h0001);
    check("t_conf_c4", conflict_v[0], 1);
    cyc(); smp(); check("t_done_c5", cpu_done_v[0], 1);
    check("t_rdata_c5", cpu_rdata_v[0], 32'hA5A5_0001);
    cyc(); cpu_req_v[0] = 1'b0;

    // Both held for 12 transactions: strict alternation, display first
    cyc(); cpu_req_v[0] = 1'b1; cpu_addr = 16'h0003; disp_req_v[0] = 1'b1; disp_addr = 16'h0004;
    for (int i = 0; i < 12; i++) begin
      wait_en(8, gap);
      if (i == 0) check("alt_first_gap", gap, 2);
      else        check("alt_gap", gap, 3);
      check("alt_addr", ram_addr_v[0], (i % 2 == 0) ? 16'h0004 : 16'h0003);
      check("alt_conf", conflict_v[0], 2 + i);
    end
    cpu_req_v[0] = 1'b0; disp_req_v[0] = 1'b0;
    repeat (4) smp();
    check("alt_quiet_en", ram_en_v[0], 0);
    check("alt_conf_end", conflict_v[0], 13);

    // Latency sweep on RD_LAT=1 and RD_LAT=4 instances
    run_lat(1);
    run_lat(2);

    // Saturation of the conflict counter
    smp();
    force u_dut.conflict_cnt = 16'hFFFE;
    #1 release u_dut.conflict_cnt;
    #1 check("sat_preload", conflict_v[0], 16'hFFFE);
    cyc(); cpu_req_v[0] = 1'b1; disp_req_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_en(8, gap);
      check("sat_gap", gap, (i == 0) ? 2 : 3);
      check("sat_conf", conflict_v[0], 16'hFFFF);
    end
    cpu_req_v[0] = 1'b0; disp_req_v[0] = 1'b0;
    repeat (4) smp();
    check("sat_conf_end", conflict_v[0], 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
